// File: rtl/id_exe_skid_reg.sv
// ID/EXE pipeline register with a ready/valid handshake, a two-entry skid
// buffer, synchronous flush (bubble insertion) and a saturating stall counter.
module id_exe_skid_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned WB_W   = 2,
  parameter int unsigned MEM_W  = 2,
  parameter int unsigned EXE_W  = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   wb,
  input  logic [MEM_W-1:0]  mem,
  input  logic [EXE_W-1:0]  exe,
  input  logic [DATA_W-1:0] ID_pc_plus4,
  input  logic [DATA_W-1:0] ID_rs,
  input  logic [DATA_W-1:0] ID_rt,
  input  logic [DATA_W-1:0] ID_immediate,
  input  logic [ADDR_W-1:0] ID_reg_address_rs,
  input  logic [ADDR_W-1:0] ID_reg_address_rt,
  input  logic [ADDR_W-1:0] ID_reg_address_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_out,
  output logic [MEM_W-1:0]  mem_out,
  output logic [EXE_W-1:0]  exe_out,
  output logic [DATA_W-1:0] EXE_pc_plus4,
  output logic [DATA_W-1:0] EXE_rs,
  output logic [DATA_W-1:0] EXE_rt,
  output logic [DATA_W-1:0] EXE_immediate,
  output logic [ADDR_W-1:0] EXE_reg_address_rs,
  output logic [ADDR_W-1:0] EXE_reg_address_rt,
  output logic [ADDR_W-1:0] EXE_reg_address_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Skid entry storage
  logic              s_valid;
  logic [WB_W-1:0]   s_wb;
  logic [MEM_W-1:0]  s_mem;
  logic [EXE_W-1:0]  s_exe;
  logic [DATA_W-1:0] s_pc_plus4;
  logic [DATA_W-1:0] s_rs;
  logic [DATA_W-1:0] s_rt;
  logic [DATA_W-1:0] s_immediate;
  logic [ADDR_W-1:0] s_addr_rs;
  logic [ADDR_W-1:0] s_addr_rt;
  logic [ADDR_W-1:0] s_addr_rd;

  logic main_free;

  // Ready depends only on the skid flag, so out_ready never reaches in_ready
  assign in_ready  = !s_valid;
  assign main_free = !out_valid || out_ready;

  // Main/skid entry update: reset, then flush, then normal handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid          <= 1'b0;
      wb_out             <= '0;
      mem_out            <= '0;
      exe_out            <= '0;
      EXE_pc_plus4       <= '0;
      EXE_rs             <= '0;
      EXE_rt             <= '0;
      EXE_immediate      <= '0;
      EXE_reg_address_rs <= '0;
      EXE_reg_address_rt <= '0;
      EXE_reg_address_rd <= '0;
      s_valid            <= 1'b0;
      s_wb               <= '0;
      s_mem              <= '0;
      s_exe              <= '0;
      s_pc_plus4         <= '0;
      s_rs               <= '0;
      s_rt               <= '0;
      s_immediate        <= '0;
      s_addr_rs          <= '0;
      s_addr_rt          <= '0;
      s_addr_rd          <= '0;
    end else if (flush) begin
      // Bubble both entries; data/address fields are left as they are
      out_valid <= 1'b0;
      wb_out    <= '0;
      mem_out   <= '0;
      exe_out   <= '0;
      s_valid   <= 1'b0;
      s_wb      <= '0;
      s_mem     <= '0;
      s_exe     <= '0;
    end else if (main_free) begin
      if (s_valid) begin
        out_valid          <= 1'b1;
        s_valid            <= 1'b0;
        wb_out             <= s_wb;
        mem_out            <= s_mem;
        exe_out            <= s_exe;
        EXE_pc_plus4       <= s_pc_plus4;
        EXE_rs             <= s_rs;
        EXE_rt             <= s_rt;
        EXE_immediate      <= s_immediate;
        EXE_reg_address_rs <= s_addr_rs;
        EXE_reg_address_rt <= s_addr_rt;
        EXE_reg_address_rd <= s_addr_rd;
      end else if (in_valid) begin
        out_valid          <= 1'b1;
        wb_out             <= wb;
        mem_out            <= mem;
        exe_out            <= exe;
        EXE_pc_plus4       <= ID_pc_plus4;
        EXE_rs             <= ID_rs;
        EXE_rt             <= ID_rt;
        EXE_immediate      <= ID_immediate;
        EXE_reg_address_rs <= ID_reg_address_rs;
        EXE_reg_address_rt <= ID_reg_address_rt;
        EXE_reg_address_rd <= ID_reg_address_rd;
      end else begin
        // Empty slot: keep control zero so a bubble has no side effects
        out_valid <= 1'b0;
        wb_out    <= '0;
        mem_out   <= '0;
        exe_out   <= '0;
      end
    end else if (in_valid && !s_valid) begin
      s_valid     <= 1'b1;
      s_wb        <= wb;
      s_mem       <= mem;
      s_exe       <= exe;
      s_pc_plus4  <= ID_pc_plus4;
      s_rs        <= ID_rs;
      s_rt        <= ID_rt;
      s_immediate <= ID_immediate;
      s_addr_rs   <= ID_reg_address_rs;
      s_addr_rt   <= ID_reg_address_rt;
      s_addr_rd   <= ID_reg_address_rd;
    end
  end

  // Saturating count of cycles the execute side holds off a valid entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_exe_skid_reg.sv
// Directed bench for id_exe_skid_reg (stall counter narrowed to 4 bits).
module tb_id_exe_skid_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned WB_W   = 2;
  localparam int unsigned MEM_W  = 2;
  localparam int unsigned EXE_W  = 6;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [WB_W-1:0]   wb;
  logic [MEM_W-1:0]  mem;
  logic [EXE_W-1:0]  exe;
  logic [DATA_W-1:0] ID_pc_plus4;
  logic [DATA_W-1:0] ID_rs;
  logic [DATA_W-1:0] ID_rt;
  logic [DATA_W-1:0] ID_immediate;
  logic [ADDR_W-1:0] ID_reg_address_rs;
  logic [ADDR_W-1:0] ID_reg_address_rt;
  logic [ADDR_W-1:0] ID_reg_address_rd;
  logic              out_valid;
  logic              out_ready;
  logic [WB_W-1:0]   wb_out;
  logic [MEM_W-1:0]  mem_out;
  logic [EXE_W-1:0]  exe_out;
  logic [DATA_W-1:0] EXE_pc_plus4;
  logic [DATA_W-1:0] EXE_rs;
  logic [DATA_W-1:0] EXE_rt;
  logic [DATA_W-1:0] EXE_immediate;
  logic [ADDR_W-1:0] EXE_reg_address_rs;
  logic [ADDR_W-1:0] EXE_reg_address_rt;
  logic [ADDR_W-1:0] EXE_reg_address_rd;
  logic [CNT_W-1:0]  stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  id_exe_skid_reg #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WB_W(WB_W),
    .MEM_W(MEM_W), .EXE_W(EXE_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .wb(wb), .mem(mem), .exe(exe),
    .ID_pc_plus4(ID_pc_plus4), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_immediate(ID_immediate),
    .ID_reg_address_rs(ID_reg_address_rs),
    .ID_reg_address_rt(ID_reg_address_rt),
    .ID_reg_address_rd(ID_reg_address_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_out(wb_out), .mem_out(mem_out), .exe_out(exe_out),
    .EXE_pc_plus4(EXE_pc_plus4), .EXE_rs(EXE_rs), .EXE_rt(EXE_rt),
    .EXE_immediate(EXE_immediate),
    .EXE_reg_address_rs(EXE_reg_address_rs),
    .EXE_reg_address_rt(EXE_reg_address_rt),
    .EXE_reg_address_rd(EXE_reg_address_rd),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a decode entry; other data fields are derived from pc
  task automatic drive(input logic v, input logic [DATA_W-1:0] pc,
                       input logic [WB_W-1:0] w, input logic [MEM_W-1:0] m,
                       input logic [EXE_W-1:0] e);
    in_valid          = v;
    ID_pc_plus4       = pc;
    ID_rs             = pc + 32'h100;
    ID_rt             = pc + 32'h200;
    ID_immediate      = pc + 32'h300;
    ID_reg_address_rs = 5'd1;
    ID_reg_address_rt = 5'd2;
    ID_reg_address_rd = 5'd3;
    wb  = w;
    mem = m;
    exe = e;
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'd44, 2'b11, 2'b11, 6'h3F);

    // Reset held two cycles with a live input
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_wb_out", 64'(wb_out), 64'd0);
    chk("rst_exe_out", 64'(exe_out), 64'd0);
    chk("rst_pc", 64'(EXE_pc_plus4), 64'd0);
    chk("rst_rd", 64'(EXE_reg_address_rd), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b1;
    drive(1'b0, 32'd0, 2'b00, 2'b00, 6'h00);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming at full rate
    out_ready = 1'b1;
    drive(1'b1, 32'd4, 2'b01, 2'b00, 6'h01);
    step();
    chk("stream_valid0", 64'(out_valid), 64'd1);
    chk("stream_pc0", 64'(EXE_pc_plus4), 64'd4);
    chk("stream_wb0", 64'(wb_out), 64'd1);
    drive(1'b1, 32'd8, 2'b01, 2'b00, 6'h01);
    step();
    chk("stream_pc1", 64'(EXE_pc_plus4), 64'd8);
    chk("stream_ready1", 64'(in_ready), 64'd1);
    drive(1'b1, 32'd12, 2'b01, 2'b00, 6'h01);
    step();
    chk("stream_pc2", 64'(EXE_pc_plus4), 64'd12);
    chk("stream_imm2", 64'(EXE_immediate), 64'h30C);
    chk("stream_valid2", 64'(out_valid), 64'd1);
    drive(1'b0, 32'd0, 2'b00, 2'b00, 6'h00);
    step();
    chk("stream_drain_valid", 64'(out_valid), 64'd0);
    chk("stream_drain_wb", 64'(wb_out), 64'd0);
    chk("stream_cnt", 64'(stall_cnt), 64'd0);

    // Backpressure: A into main, B into skid
    out_ready = 1'b0;
    drive(1'b1, 32'd4, 2'b10, 2'b01, 6'h0A);
    step();
    chk("bp_a_pc", 64'(EXE_pc_plus4), 64'd4);
    chk("bp_a_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'd8, 2'b01, 2'b10, 6'h0B);
    step();
    chk("bp_b_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_pc", 64'(EXE_pc_plus4), 64'd4);
    drive(1'b0, 32'd0, 2'b00, 2'b00, 6'h00);
    step();
    step();
    chk("bp_hold_pc2", 64'(EXE_pc_plus4), 64'd4);
    chk("bp_hold_exe", 64'(exe_out), 64'h0A);
    chk("bp_cnt", 64'(stall_cnt), 64'd3);
    out_ready = 1'b1;
    step();
    chk("bp_b_pc", 64'(EXE_pc_plus4), 64'd8);
    chk("bp_b_exe", 64'(exe_out), 64'h0B);
    chk("bp_b_valid", 64'(out_valid), 64'd1);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    chk("bp_cnt_hold", 64'(stall_cnt), 64'd3);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush with both entries full and an entry offered
    out_ready = 1'b0;
    drive(1'b1, 32'd16, 2'b01, 2'b01, 6'h05);
    step();
    drive(1'b1, 32'd20, 2'b10, 2'b10, 6'h06);
    step();
    chk("fl_pre_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'd24, 2'b11, 2'b11, 6'h3F);
    step();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_wb", 64'(wb_out), 64'd0);
    chk("fl_mem", 64'(mem_out), 64'd0);
    chk("fl_exe", 64'(exe_out), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    chk("fl_pc_hold", 64'(EXE_pc_plus4), 64'd16);
    chk("fl_cnt", 64'(stall_cnt), 64'd5);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 2'b00, 2'b00, 6'h00);
    step();
    chk("fl_after_valid", 64'(out_valid), 64'd0);
    chk("fl_after_pc", 64'(EXE_pc_plus4), 64'd16);
    step();
    chk("fl_after_valid2", 64'(out_valid), 64'd0);

    // Saturation of the 4-bit stall counter
    out_ready = 1'b0;
    drive(1'b1, 32'd28, 2'b01, 2'b00, 6'h02);
    step();
    drive(1'b0, 32'd0, 2'b00, 2'b00, 6'h00);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 9) chk("sat_cnt14", 64'(stall_cnt), 64'd14);
      if (i == 10) chk("sat_cnt15", 64'(stall_cnt), 64'd15);
    end
    chk("sat_cnt_stay", 64'(stall_cnt), 64'd15);
    chk("sat_pc_hold", 64'(EXE_pc_plus4), 64'd28);

    // Reset while stalled with the skid entry full
    drive(1'b1, 32'd32, 2'b11, 2'b11, 6'h07);
    step();
    chk("mr_full", 64'(in_ready), 64'd0);
    rst = 1'b0;
    drive(1'b1, 32'd36, 2'b11, 2'b11, 6'h08);
    step();
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_ready", 64'(in_ready), 64'd1);
    chk("mr_cnt", 64'(stall_cnt), 64'd0);
    chk("mr_pc", 64'(EXE_pc_plus4), 64'd0);
    chk("mr_wb", 64'(wb_out), 64'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 2'b00, 2'b00, 6'h00);
    step();
    chk("mr_no_stale", 64'(out_valid), 64'd0);
    step();
    chk("mr_no_stale2", 64'(out_valid), 64'd0);
    chk("mr_pc_after", 64'(EXE_pc_plus4), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
